// File: rtl/sdram_arb_pkg.sv
// Shared state encodings and operation constants for the SDRAM user-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_ST_IDLE  = 2'd0,
    ARB_ST_ISSUE = 2'd1,
    ARB_ST_DONE  = 2'd2
  } arb_state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // A requester raising both strobes is served as a write.
  function automatic logic op_sel(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Combinational round-robin pick: first pending index after 'last', wrapping modulo NUM_REQ.
module sdram_arb_rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      grant,
  output logic               valid
);

  int idx;

  // Walk farthest-to-nearest so the nearest pending index after 'last' wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = (int'(last) + k) % int'(NUM_REQ);
      if (pending[idx]) begin
        grant = IW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Round-robin arbiter sharing one sdram_ctrl user port between NUM_REQ requesters, one op in flight.
// Optional SDRAM_ARB_PRIO0_EN: requester 0 gets absolute priority; the others rotate among themselves.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned AW      = 32,
  parameter  int unsigned DW      = 16,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ*DW-1:0] req_wr_data,
  output logic [DW-1:0]         req_rd_data,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [AW-1:0]         sdram_addr,
  output logic                  sdram_wr,
  output logic                  sdram_rd,
  output logic [DW-1:0]         sdram_wr_data,
  input  logic [DW-1:0]         sdram_rd_data,
  input  logic                  sdram_op_done,
  output logic                  busy,
  output logic [IW-1:0]         grant_id
);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [NUM_REQ-1:0]   pending, rr_pending;
  logic [IW-1:0]        rr_grant, sel_id;
  logic                 rr_valid, sel_valid, sel_ptr;
  logic [AW-1:0]        sel_addr, addr_d;
  logic [DW-1:0]        sel_wdata, wdata_d, rdata_d;
  logic                 sel_wr, wr_d, rd_d, busy_d;
  logic [IW-1:0]        grant_d;
  logic [NUM_REQ-1:0]   done_d;

  assign pending = req_wr | req_rd;

`ifdef SDRAM_ARB_PRIO0_EN
  assign rr_pending = pending & ~NUM_REQ'(1);
`else
  assign rr_pending = pending;
`endif

  sdram_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pending (rr_pending),
    .last    (last_q),
    .grant   (rr_grant),
    .valid   (rr_valid)
  );

  // Final winner; sel_ptr says whether this grant advances the rotation pointer.
  always_comb begin
    sel_id    = rr_grant;
    sel_valid = rr_valid;
    sel_ptr   = 1'b1;
`ifdef SDRAM_ARB_PRIO0_EN
    if (pending[0]) begin
      sel_id    = '0;
      sel_valid = 1'b1;
      sel_ptr   = 1'b0;
    end
`endif
  end

  // Route the winner's payload.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (sel_id == IW'(i)) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wr_data[i*DW +: DW];
        sel_wr    = req_wr[i];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = sdram_addr;
    wdata_d = sdram_wr_data;
    wr_d    = sdram_wr;
    rd_d    = sdram_rd;
    grant_d = grant_id;
    rdata_d = req_rd_data;
    done_d  = '0;
    unique case (state_q)
      ARB_ST_IDLE: begin
        if (sel_valid) begin
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wr_d    = (op_sel(sel_wr) == OP_WR);
          rd_d    = (op_sel(sel_wr) == OP_RD);
          grant_d = sel_id;
          if (sel_ptr) last_d = sel_id;
          state_d = ARB_ST_ISSUE;
        end
      end
      ARB_ST_ISSUE: begin
        if (sdram_op_done) begin
          wr_d = 1'b0;
          rd_d = 1'b0;
          if (sdram_rd) rdata_d = sdram_rd_data;
          done_d  = NUM_REQ'(1) << grant_id;
          state_d = ARB_ST_DONE;
        end
      end
      ARB_ST_DONE: state_d = ARB_ST_IDLE;
      default:     state_d = ARB_ST_IDLE;
    endcase
    busy_d = (state_d != ARB_ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_ST_IDLE;
      last_q        <= IW'(NUM_REQ - 1);
      sdram_addr    <= '0;
      sdram_wr_data <= '0;
      sdram_wr      <= 1'b0;
      sdram_rd      <= 1'b0;
      grant_id      <= '0;
      req_rd_data   <= '0;
      req_done      <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      sdram_addr    <= addr_d;
      sdram_wr_data <= wdata_d;
      sdram_wr      <= wr_d;
      sdram_rd      <= rd_d;
      grant_id      <= grant_d;
      req_rd_data   <= rdata_d;
      req_done      <= done_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Randomized bench for sdram_arb: random requesters and SDRAM latency against a transaction-level model.
module tb_sdram_arb;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 16;
  localparam int unsigned IW      = $clog2(NUM_REQ);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_wr, req_rd;
  logic [NUM_REQ*DW-1:0] req_wr_data;
  logic [DW-1:0]         req_rd_data;
  logic [NUM_REQ-1:0]    req_done;
  logic [AW-1:0]         sdram_addr;
  logic                  sdram_wr, sdram_rd;
  logic [DW-1:0]         sdram_wr_data, sdram_rd_data;
  logic                  sdram_op_done, busy;
  logic [IW-1:0]         grant_id;

  sdram_arb #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_addr      (req_addr),
    .req_wr        (req_wr),
    .req_rd        (req_rd),
    .req_wr_data   (req_wr_data),
    .req_rd_data   (req_rd_data),
    .req_done      (req_done),
    .sdram_addr    (sdram_addr),
    .sdram_wr      (sdram_wr),
    .sdram_rd      (sdram_rd),
    .sdram_wr_data (sdram_wr_data),
    .sdram_rd_data (sdram_rd_data),
    .sdram_op_done (sdram_op_done),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Transaction model: who owns the port, what was latched, when the next grant may happen.
  int            last_ptr, t_free, lat, cur_g, done_g;
  bit            in_flight, force_all;
  bit            cur_wr;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, rd_exp;
  logic [DW-1:0] mem [16];
  bit            active [NUM_REQ];
  int            gap    [NUM_REQ];
  logic [1:0]    opk    [NUM_REQ];
  int            served [NUM_REQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [NUM_REQ-1:0] pend);
`ifdef SDRAM_ARB_PRIO0_EN
    if (pend[0]) return 0;
    pend[0] = 1'b0;
`endif
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      int c;
      c = (last_ptr + k) % int'(NUM_REQ);
      if (pend[c]) begin
        last_ptr = c;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic expect_outputs(input string ph, input bit cmd_on, input bit busy_e,
                                input logic [NUM_REQ-1:0] done_e);
    check({ph, "_wr"}, 64'(sdram_wr), 64'(cmd_on & cur_wr));
    check({ph, "_rd"}, 64'(sdram_rd), 64'(cmd_on & !cur_wr));
    if (cmd_on) begin
      check({ph, "_addr"}, 64'(sdram_addr), 64'(cur_addr));
      check({ph, "_wdata"}, 64'(sdram_wr_data), 64'(cur_wdata));
    end
    check({ph, "_grant"}, 64'(grant_id), 64'(cur_g));
    check({ph, "_busy"}, 64'(busy), 64'(busy_e));
    check({ph, "_done"}, 64'(req_done), 64'(done_e));
    check({ph, "_rdata"}, 64'(req_rd_data), 64'(rd_exp));
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, "_wr"}, 64'(sdram_wr), 64'd0);
    check({ph, "_rd"}, 64'(sdram_rd), 64'd0);
    check({ph, "_busy"}, 64'(busy), 64'd0);
    check({ph, "_done"}, 64'(req_done), 64'd0);
    check({ph, "_grant"}, 64'(grant_id), 64'd0);
    check({ph, "_rdata"}, 64'(req_rd_data), 64'd0);
    check({ph, "_addr"}, 64'(sdram_addr), 64'd0);
  endtask

  task automatic model_reset();
    last_ptr      = int'(NUM_REQ) - 1;
    t_free        = 0;
    lat           = -1;
    cur_g         = 0;
    done_g        = -1;
    in_flight     = 1'b0;
    cur_wr        = 1'b0;
    rd_exp        = '0;
    sdram_op_done = 1'b0;
  endtask

  task automatic drive_requesters();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (i == done_g) begin
        active[i] = 1'b0;
        gap[i]    = force_all ? 0 : int'($urandom_range(0, 2));
      end else if (!active[i]) begin
        if (gap[i] > 0) gap[i]--;
        else if (force_all || $urandom_range(0, 2) == 0) begin
          active[i] = 1'b1;
          opk[i]    = 2'($urandom_range(1, 3));
        end
      end else if (!force_all && in_flight && i == cur_g && $urandom_range(0, 15) == 0) begin
        active[i] = 1'b0;
      end
      req_wr[i] = active[i] & opk[i][0];
      req_rd[i] = active[i] & opk[i][1];
      req_addr[i*AW +: AW]    = AW'($urandom);
      req_wr_data[i*DW +: DW] = DW'($urandom);
    end
  endtask

  // One clock: compare DUT against the model, then drive the next inputs.
  task automatic step();
    logic [NUM_REQ-1:0]    pw, pr, pend;
    logic [NUM_REQ*AW-1:0] pa;
    logic [NUM_REQ*DW-1:0] pd;
    logic                  pdone;
    logic [DW-1:0]         prd;
    pw = req_wr; pr = req_rd; pa = req_addr; pd = req_wr_data;
    pdone = sdram_op_done; prd = sdram_rd_data;
    @(posedge clk);
    #1;
    cyc++;
    done_g = -1;
    pend = pw | pr;
    if (in_flight && pdone) begin
      if (!cur_wr) rd_exp = prd;
      expect_outputs("done", 1'b0, 1'b1, NUM_REQ'(1) << cur_g);
      served[cur_g]++;
      done_g    = cur_g;
      in_flight = 1'b0;
      t_free    = cyc + 2;
    end else if (in_flight) begin
      expect_outputs("hold", 1'b1, 1'b1, '0);
    end else if (cyc >= t_free && pend != '0) begin
      cur_g     = model_pick(pend);
      cur_wr    = pw[cur_g];
      cur_addr  = pa[cur_g*AW +: AW];
      cur_wdata = pd[cur_g*DW +: DW];
      in_flight = 1'b1;
      lat       = int'($urandom_range(0, 3));
      expect_outputs("grant", 1'b1, 1'b1, '0);
    end else begin
      expect_outputs("idle", 1'b0, 1'b0, '0);
    end

    sdram_op_done = 1'b0;
    sdram_rd_data = DW'($urandom);
    if (in_flight && lat == 0) begin
      sdram_op_done = 1'b1;
      lat = -1;
      if (cur_wr) mem[cur_addr[3:0]] = cur_wdata;
      else        sdram_rd_data = mem[cur_addr[3:0]];
    end else if (in_flight && lat > 0) begin
      lat--;
    end else if (!in_flight && $urandom_range(0, 7) == 0) begin
      sdram_op_done = 1'b1;
    end
    drive_requesters();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      active[i] = 1'b0; gap[i] = 0; opk[i] = 2'd1; served[i] = 0;
    end
    reset = 1'b0;
    req_wr = '0; req_rd = '0; req_addr = '0; req_wr_data = '0;
    sdram_rd_data = '0;
    force_all = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b1;

    repeat (1200) step();
    force_all = 1'b1;
    repeat (150) step();
    force_all = 1'b0;
    repeat (600) step();

    // Reset while an operation is in flight.
    force_all = 1'b1;
    n = 0;
    while (!in_flight && n < 50) begin
      step();
      n++;
    end
    check("reach_issue", 64'(sdram_wr | sdram_rd), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    model_reset();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      active[i] = 1'b1;
      opk[i]    = 2'($urandom_range(1, 3));
      req_wr[i] = opk[i][0];
      req_rd[i] = opk[i][1];
    end
    reset = 1'b1;
    n = 0;
    while (!in_flight && n < 10) begin
      step();
      n++;
    end
    check("post_rst_grant", 64'(grant_id), 64'd0);
    check("post_rst_cmd", 64'(sdram_wr | sdram_rd), 64'd1);
    force_all = 1'b0;
    repeat (300) step();

    for (int i = 0; i < int'(NUM_REQ); i++) check("served", 64'(served[i] > 0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
